wb_j1_bridge_ws: RTL and testbench
==================================

// Module: wb_j1_bridge_ws
// PURPOSE
//  Wait-state capable successor of the zero-wait J1 bus bridge. Joins the J1 instruction bus (ibus)
//  and data bus (dbus) onto one Wishbone classic master port, handling slave wait states via wb_ack_i/wb_err_i.
//  Serialises simultaneous ibus+dbus accesses, and holds the J1 core with j1_stall until all data has returned.
// PARAMETERS
//  AW          16      address width, ibus/dbus/wb
//  DW          16      data width, multiple of 8
//  DBUS_FIRST  1       1: dbus access issued before ibus when both requested in same cycle; 0: ibus first
//  ERR_DATA    '0      read data returned to core on wb_err_i or timeout
//  TIMEOUT     255     wait-state cycles before abort (used only with WB_J1_TIMEOUT_EN), 1..2**16-1
// PORTS
//  clk         in   1     system clock, all logic rising-edge
//  reset       in   1     synchronous, active-high
//  ibus_re     in   1     instruction fetch request; held with ibus_adr stable while j1_stall=1
//  ibus_adr    in   AW    fetch address
//  ibus_dat    out  DW    fetched instruction; valid in RESP cycle, held until next RESP
//  dbus_re     in   1     data read request
//  dbus_we     in   1     data write request (dbus_re & dbus_we together: write wins, no read data)
//  dbus_adr    in   AW    data address
//  dbus_dat_m  in   DW    write data
//  dbus_dat_s  out  DW    read data; valid in RESP cycle, held until next RESP
//  j1_stall    out  1     core hold; combinational from requests in IDLE, registered state otherwise
//  bus_error   out  1     one-cycle pulse in RESP if any access of the batch ended by err/timeout
//  wb_cyc_o, wb_stb_o  out 1   cycle/strobe, always equal
//  wb_we_o     out  1     write enable
//  wb_adr_o    out  AW    registered address
//  wb_dat_o    out  DW    registered write data
//  wb_sel_o    out  DW/8  all ones
//  wb_dat_i    in   DW    slave read data
//  wb_ack_i    in   1     slave acknowledge
//  wb_err_i    in   1     slave error termination
// BEHAVIOUR
//  Reset: state IDLE; wb_cyc_o/stb_o/we_o=0, wb_adr_o/wb_dat_o=0, ibus_dat/dbus_dat_s=0, bus_error=0; j1_stall=0 absent requests.
//  FSM states IDLE, DBUS, IBUS, RESP.
//  IDLE: any of ibus_re|dbus_re|dbus_we -> j1_stall=1 same cycle; latch pending flags, addr, data.
//    Go to first pending access per DBUS_FIRST.
//  DBUS/IBUS: cyc=stb=1 from first cycle in state; adr/we/dat registered, stable until termination.
//    Terminated by wb_ack_i or wb_err_i sampled high (ack wins if both).
//    Capture wb_dat_i (or ERR_DATA on err) into holding register; on err set batch error flag.
//    Next: other pending access if any, else RESP. Between accesses cyc/stb drop for exactly one cycle.
//  RESP: j1_stall=0, output data registers valid, bus_error=batch flag, requests ignored. -> IDLE.
//  Latency, zero-wait slave (ack in first stb cycle): single access stalls 2 cycles, dual 4 cycles.
//    Each slave wait state adds one cycle.
//  Write-only batch: dbus_dat_s keeps previous value.
//  Reset mid-access: next edge cyc/stb=0, IDLE, held data cleared; no response delivered.
//  Bridge never asserts stb without cyc; never issues two accesses in one cycle.
// CONFIGURATION
//  WB_J1_TIMEOUT_EN defined:
//    Wait counter cleared on entering DBUS/IBUS, incremented each unterminated cycle.
//    Reaching TIMEOUT aborts: cyc/stb drop, data=ERR_DATA, error flag set, FSM proceeds as on err.
//  WB_J1_TIMEOUT_EN undefined: no counter, bridge waits indefinitely for ack/err; TIMEOUT ignored.
// STRUCTURE
//  Package wb_j1_pkg: state enum typedef (IDLE,DBUS,IBUS,RESP); default AW/DW localparams.
//  Sub-module wb_j1_watchdog (clk, reset, clr, en, expired; param TIMEOUT), instantiated only under WB_J1_TIMEOUT_EN.
// TESTING
//  1. ibus_re=1 adr=0x0010, slave acks 1st cycle with 0x6023:
//     j1_stall high 2 cycles, ibus_dat=0x6023 in RESP, one WB cycle adr=0x0010.
//  2. Simultaneous ibus_re adr=0x0020 + dbus_we adr=0x4000 dat=0xBEEF, DBUS_FIRST=1:
//     write 0x4000 first, then read 0x0020; cyc gap 1 cycle; stall 4 cycles.
//  3. dbus_re adr=0x4002, slave 3 wait states then ack 0x1234:
//     stb held 4 cycles with stable adr, stall 5 cycles, dbus_dat_s=0x1234.
//  4. dbus_re, slave asserts wb_err_i:
//     dbus_dat_s=ERR_DATA, bus_error pulses exactly 1 cycle in RESP.
//  5. TIMEOUT=8 with WB_J1_TIMEOUT_EN, slave never acks:
//     abort after 8 wait cycles, bus_error=1. Without macro: stb stays high 1000 cycles.
//  6. reset asserted in 2nd wait cycle of dbus read:
//     next edge cyc=0, stall=0, dbus_dat_s=0; fresh request afterwards completes normally.

Source files
------------

// File: rtl/wb_j1_pkg.sv
// Shared types and defaults for the J1-to-Wishbone wait-state bridge.
package wb_j1_pkg;

   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;

   // Bridge sequencing states: idle, data access, fetch access, response to core
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DBUS = 2'd1,
      IBUS = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/wb_j1_watchdog.sv
// Wait-state watchdog: counts unterminated bus cycles and flags expiry once the
// access has spent TIMEOUT cycles waiting. Only instantiated when
// WB_J1_TIMEOUT_EN is defined.
module wb_j1_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt;

   // Count waiting cycles; cleared whenever no access is on the bus
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 16'd1;
      end
   end

   // The cycle in which the count reaches TIMEOUT-1 is the last waiting cycle
   assign expired = (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/wb_j1_bridge_ws.sv
// J1 ibus/dbus to Wishbone classic bridge with slave wait-state support.
// Simultaneous fetch and data requests are serialised into separate Wishbone
// cycles separated by one idle cycle; the core is stalled until all data of
// the batch is back. Optional macro WB_J1_TIMEOUT_EN adds a wait-state
// watchdog that aborts an access after TIMEOUT unterminated cycles.
module wb_j1_bridge_ws
   import wb_j1_pkg::*;
#(
   parameter int            AW         = DEF_AW,
   parameter int            DW         = DEF_DW,
   parameter int            DBUS_FIRST = 1,
   parameter logic [DW-1:0] ERR_DATA   = '0,
   parameter int            TIMEOUT    = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ibus_re,
   input  logic [AW-1:0]   ibus_adr,
   output logic [DW-1:0]   ibus_dat,
   input  logic            dbus_re,
   input  logic            dbus_we,
   input  logic [AW-1:0]   dbus_adr,
   input  logic [DW-1:0]   dbus_dat_m,
   output logic [DW-1:0]   dbus_dat_s,
   output logic            j1_stall,
   output logic            bus_error,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i
);

   state_t        state, state_nx;
   logic          gap_q, gap_nx;

   logic          pend_i, pend_d;     // accesses of the batch still to be issued
   logic          dwe_q;              // data access is a write
   logic          b_i, b_dr;          // batch contains a fetch / a data read
   logic          err_q;              // some access of the batch failed
   logic [AW-1:0] iadr_q, dadr_q, adr_q;
   logic [DW-1:0] ddat_q, dat_q;
   logic          we_q;
   logic [DW-1:0] hold_i, hold_d;
   logic [DW-1:0] ibus_dat_q, dbus_dat_q;

   logic          req, d_first, active, more;
   logic          term_ok, term_bad, term;
   logic          to_exp;
   logic [DW-1:0] cap;

   assign req     = ibus_re | dbus_re | dbus_we;
   assign d_first = (dbus_re | dbus_we) & ((DBUS_FIRST != 0) | ~ibus_re);

   // An access owns the bus in DBUS/IBUS except during the one-cycle gap
   assign active   = ((state == DBUS) || (state == IBUS)) && !gap_q;
   assign term_ok  = active & wb_ack_i;
   assign term_bad = active & ~wb_ack_i & (wb_err_i | to_exp);
   assign term     = term_ok | term_bad;
   assign cap      = wb_ack_i ? wb_dat_i : ERR_DATA;
   assign more     = (state == DBUS) ? pend_i : pend_d;

`ifdef WB_J1_TIMEOUT_EN
   logic wd_en;

   assign wd_en = active & ~wb_ack_i & ~wb_err_i;

   wb_j1_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (!active),
      .en      (wd_en),
      .expired (to_exp)
   );
`else
   // No watchdog: TIMEOUT is always positive, so this stays low and the
   // bridge waits indefinitely for ack/err
   assign to_exp = (TIMEOUT < 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         gap_q <= 1'b0;
      end else begin
         state <= state_nx;
         gap_q <= gap_nx;
      end
   end

   // Next-state and stall decode
   always_comb begin
      state_nx = state;
      gap_nx   = gap_q;
      j1_stall = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               j1_stall = 1'b1;
               state_nx = d_first ? DBUS : IBUS;
            end
         end
         DBUS, IBUS: begin
            j1_stall = 1'b1;
            if (gap_q) begin
               gap_nx   = 1'b0;
               state_nx = (state == DBUS) ? IBUS : DBUS;
            end else if (term) begin
               if (more) gap_nx = 1'b1;
               else      state_nx = RESP;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            gap_nx   = 1'b0;
         end
      endcase
   end

   // Batch capture, Wishbone address/data registers and returned data
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_i     <= 1'b0;
         pend_d     <= 1'b0;
         dwe_q      <= 1'b0;
         b_i        <= 1'b0;
         b_dr       <= 1'b0;
         err_q      <= 1'b0;
         iadr_q     <= '0;
         dadr_q     <= '0;
         ddat_q     <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         we_q       <= 1'b0;
         hold_i     <= '0;
         hold_d     <= '0;
         ibus_dat_q <= '0;
         dbus_dat_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  pend_i <= ibus_re;
                  pend_d <= dbus_re | dbus_we;
                  dwe_q  <= dbus_we;
                  b_i    <= ibus_re;
                  b_dr   <= dbus_re & ~dbus_we;
                  err_q  <= 1'b0;
                  iadr_q <= ibus_adr;
                  dadr_q <= dbus_adr;
                  ddat_q <= dbus_dat_m;
                  adr_q  <= d_first ? dbus_adr : ibus_adr;
                  we_q   <= d_first & dbus_we;
                  dat_q  <= d_first ? dbus_dat_m : '0;
               end
            end
            DBUS, IBUS: begin
               if (gap_q) begin
                  // Load the second access of the batch
                  if (state == DBUS) begin
                     adr_q <= iadr_q;
                     we_q  <= 1'b0;
                     dat_q <= '0;
                  end else begin
                     adr_q <= dadr_q;
                     we_q  <= dwe_q;
                     dat_q <= ddat_q;
                  end
               end else if (term) begin
                  if (term_bad) err_q <= 1'b1;
                  if (state == DBUS) begin
                     pend_d <= 1'b0;
                     hold_d <= cap;
                  end else begin
                     pend_i <= 1'b0;
                     hold_i <= cap;
                  end
                  // Last access: publish the batch results for the RESP cycle
                  if (!more) begin
                     if (b_i)  ibus_dat_q <= (state == IBUS) ? cap : hold_i;
                     if (b_dr) dbus_dat_q <= (state == DBUS) ? cap : hold_d;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign wb_cyc_o   = active;
   assign wb_stb_o   = active;
   assign wb_we_o    = active & we_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign wb_sel_o   = '1;
   assign ibus_dat   = ibus_dat_q;
   assign dbus_dat_s = dbus_dat_q;
   assign bus_error  = (state == RESP) & err_q;

endmodule

// File: tb/tb_wb_j1_bridge_ws.sv
// Bench for wb_j1_bridge_ws: scripted scenarios plus randomized batches against
// a transaction-level model of the bridge (issue order, stall length, data).
module tb_wb_j1_bridge_ws;

   localparam int            DBF  = 1;
   localparam int            TO   = 8;
   localparam logic [15:0]   ERRD = 16'hDEAD;

   logic        clk = 1'b0;
   logic        reset;
   logic        ibus_re, dbus_re, dbus_we;
   logic [15:0] ibus_adr, dbus_adr, dbus_dat_m;
   logic [15:0] ibus_dat, dbus_dat_s;
   logic        j1_stall, bus_error;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [1:0]  wb_sel_o;
   logic        wb_ack_i, wb_err_i;

   always #5 clk = ~clk;

   wb_j1_bridge_ws #(
      .AW (16), .DW (16), .DBUS_FIRST (DBF), .ERR_DATA (ERRD), .TIMEOUT (TO)
   ) dut (
      .clk (clk), .reset (reset),
      .ibus_re (ibus_re), .ibus_adr (ibus_adr), .ibus_dat (ibus_dat),
      .dbus_re (dbus_re), .dbus_we (dbus_we), .dbus_adr (dbus_adr),
      .dbus_dat_m (dbus_dat_m), .dbus_dat_s (dbus_dat_s),
      .j1_stall (j1_stall), .bus_error (bus_error),
      .wb_cyc_o (wb_cyc_o), .wb_stb_o (wb_stb_o), .wb_we_o (wb_we_o),
      .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel_o),
      .wb_dat_i (wb_dat_i), .wb_ack_i (wb_ack_i), .wb_err_i (wb_err_i)
   );

   int checks = 0;
   int fails  = 0;

   // Slave behaviour per access (indexed by access number mod 4):
   // mode 0 ack, 1 err, 2 ack+err together, 3 never terminate
   int          cfg_wait [4];
   int          cfg_mode [4];
   logic        ovr_en = 1'b0;
   logic [15:0] ovr_adr = '0, ovr_dat = '0;

   int sidx = 0, wcnt = 0, lidx = 0, cycn = 0, cur_start = 0;
   int cs_err = 0, adr_err = 0;
   logic        prev_stb = 1'b0;
   logic [15:0] prev_adr = '0;
   logic        log_we    [64];
   logic [15:0] log_adr   [64];
   logic [15:0] log_dat   [64];
   int          log_start [64];
   int          log_end   [64];

   logic [15:0] exp_ibus = '0, exp_dbus = '0;

   function automatic logic [15:0] rd_val(input logic [15:0] a);
      if (ovr_en && a == ovr_adr) return ovr_dat;
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   // Slave response
   always_comb begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = rd_val(wb_adr_o);
      if (wb_cyc_o && wb_stb_o && wcnt >= cfg_wait[sidx % 4]) begin
         case (cfg_mode[sidx % 4])
            0: wb_ack_i = 1'b1;
            1: wb_err_i = 1'b1;
            2: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
            default: ;
         endcase
      end
   end

   // Bus monitor: logs each terminated access and protocol anomalies
   always @(posedge clk) begin
      cycn     <= cycn + 1;
      prev_stb <= wb_stb_o;
      prev_adr <= wb_adr_o;
      if (wb_stb_o !== wb_cyc_o) cs_err <= cs_err + 1;
      if (wb_stb_o && prev_stb && wb_adr_o !== prev_adr) adr_err <= adr_err + 1;
      if (wb_stb_o && !prev_stb) cur_start <= cycn;
      if (reset) begin
         wcnt <= 0;
      end else if (wb_stb_o) begin
         if (wb_ack_i || wb_err_i) begin
            log_we[lidx % 64]    <= wb_we_o;
            log_adr[lidx % 64]   <= wb_adr_o;
            log_dat[lidx % 64]   <= wb_dat_o;
            log_start[lidx % 64] <= prev_stb ? cur_start : cycn;
            log_end[lidx % 64]   <= cycn;
            lidx <= lidx + 1;
            sidx <= sidx + 1;
            wcnt <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   task automatic run_batch(input string nm, input logic ire, input logic dre, input logic dwe,
                            input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dd,
                            input int w0, input int m0, input int w1, input int m1);
      int n, bs, bl, k, exp_k, exp_log, cs0, ad0;
      bit has_d, d_first, exp_err, bad;
      logic [15:0] e_i, e_d, rv;
      logic [15:0] a_adr [2];
      bit a_we [2], a_d [2];
      int a_w [2], a_m [2];
      has_d   = dre | dwe;
      d_first = has_d && (DBF != 0 || !ire);
      n = 0;
      if (d_first) begin
         a_d[n] = 1; a_adr[n] = da; a_we[n] = dwe; n++;
         if (ire) begin a_d[n] = 0; a_adr[n] = ia; a_we[n] = 0; n++; end
      end else begin
         if (ire) begin a_d[n] = 0; a_adr[n] = ia; a_we[n] = 0; n++; end
         if (has_d) begin a_d[n] = 1; a_adr[n] = da; a_we[n] = dwe; n++; end
      end
      a_w[0] = w0; a_m[0] = m0; a_w[1] = w1; a_m[1] = m1;
      bs = sidx; bl = lidx; cs0 = cs_err; ad0 = adr_err;
      exp_k = n; exp_err = 0; exp_log = 0; e_i = exp_ibus; e_d = exp_dbus;
      for (int i = 0; i < n; i++) begin
         cfg_wait[(bs + i) % 4] = a_w[i];
         cfg_mode[(bs + i) % 4] = a_m[i];
         exp_k += (a_m[i] == 3) ? TO : a_w[i] + 1;
         bad = (a_m[i] == 1) || (a_m[i] == 3);
         exp_err |= bad;
         if (a_m[i] != 3) exp_log++;
         rv = bad ? ERRD : rd_val(a_adr[i]);
         if (!a_d[i]) e_i = rv;
         else if (!a_we[i]) e_d = rv;
      end
      @(negedge clk);
      ibus_re = ire; dbus_re = dre; dbus_we = dwe;
      ibus_adr = ia; dbus_adr = da; dbus_dat_m = dd;
      k = 0;
      #1;
      while (j1_stall && k < 2000) begin
         k++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (k !== exp_k) begin
         fails++;
         $display("FAIL %s stall_cycles: got %0d expected %0d", nm, k, exp_k);
      end
      checks++;
      if (ibus_dat !== e_i) begin
         fails++;
         $display("FAIL %s ibus_dat: got %h expected %h", nm, ibus_dat, e_i);
      end
      checks++;
      if (dbus_dat_s !== e_d) begin
         fails++;
         $display("FAIL %s dbus_dat_s: got %h expected %h", nm, dbus_dat_s, e_d);
      end
      checks++;
      if (bus_error !== exp_err) begin
         fails++;
         $display("FAIL %s bus_error_resp: got %b expected %b", nm, bus_error, exp_err);
      end
      ibus_re = 0; dbus_re = 0; dbus_we = 0;
      @(negedge clk);
      #1;
      checks++;
      if (bus_error !== 1'b0 || j1_stall !== 1'b0) begin
         fails++;
         $display("FAIL %s after_resp: bus_error=%b stall=%b expected 0/0", nm, bus_error, j1_stall);
      end
      checks++;
      if (lidx - bl !== exp_log) begin
         fails++;
         $display("FAIL %s wb_access_count: got %0d expected %0d", nm, lidx - bl, exp_log);
      end else begin
         for (int i = 0; i < exp_log; i++) begin
            checks++;
            if (log_adr[(bl + i) % 64] !== a_adr[i] || log_we[(bl + i) % 64] !== a_we[i] ||
                (a_we[i] && log_dat[(bl + i) % 64] !== dd) ||
                log_end[(bl + i) % 64] - log_start[(bl + i) % 64] !== a_w[i]) begin
               fails++;
               $display("FAIL %s access%0d: adr=%h we=%b dat=%h len=%0d expected adr=%h we=%b dat=%h len=%0d",
                        nm, i, log_adr[(bl + i) % 64], log_we[(bl + i) % 64], log_dat[(bl + i) % 64],
                        log_end[(bl + i) % 64] - log_start[(bl + i) % 64] + 1,
                        a_adr[i], a_we[i], dd, a_w[i] + 1);
            end
         end
         if (exp_log == 2) begin
            checks++;
            if (log_start[(bl + 1) % 64] - log_end[bl % 64] !== 2) begin
               fails++;
               $display("FAIL %s cyc_gap: got %0d idle cycles expected 1", nm,
                        log_start[(bl + 1) % 64] - log_end[bl % 64] - 1);
            end
         end
      end
      checks++;
      if (cs_err !== cs0 || adr_err !== ad0) begin
         fails++;
         $display("FAIL %s protocol: stb/cyc mismatches %0d, unstable adr %0d, expected 0/0",
                  nm, cs_err - cs0, adr_err - ad0);
      end
      exp_ibus = e_i;
      exp_dbus = e_d;
   endtask

   task automatic test_reset();
      reset = 1; ibus_re = 0; dbus_re = 0; dbus_we = 0;
      ibus_adr = '0; dbus_adr = '0; dbus_dat_m = '0;
      repeat (3) @(negedge clk);
      reset = 0;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, j1_stall, bus_error} !== 5'b0 ||
          wb_adr_o !== 16'h0 || wb_dat_o !== 16'h0 || ibus_dat !== 16'h0 ||
          dbus_dat_s !== 16'h0 || wb_sel_o !== 2'b11) begin
         fails++;
         $display("FAIL reset_state: cyc=%b stb=%b we=%b stall=%b err=%b adr=%h dat=%h idat=%h ddat=%h sel=%b expected all 0, sel 11",
                  wb_cyc_o, wb_stb_o, wb_we_o, j1_stall, bus_error, wb_adr_o, wb_dat_o,
                  ibus_dat, dbus_dat_s, wb_sel_o);
      end
      exp_ibus = '0;
      exp_dbus = '0;
   endtask

   task automatic test_directed();
      ovr_en = 1; ovr_adr = 16'h0010; ovr_dat = 16'h6023;
      run_batch("fetch_zero_wait", 1, 0, 0, 16'h0010, 16'h0, 16'h0, 0, 0, 0, 0);
      run_batch("dual_write_fetch", 1, 0, 1, 16'h0020, 16'h4000, 16'hBEEF, 0, 0, 0, 0);
      ovr_adr = 16'h4002; ovr_dat = 16'h1234;
      run_batch("read_3_waits", 0, 1, 0, 16'h0, 16'h4002, 16'h0, 3, 0, 0, 0);
      run_batch("read_err", 0, 1, 0, 16'h0, 16'h4004, 16'h0, 1, 1, 0, 0);
      run_batch("write_only_keeps", 0, 0, 1, 16'h0, 16'h4006, 16'h5555, 0, 0, 0, 0);
      run_batch("re_we_write_wins", 0, 1, 1, 16'h0, 16'h4008, 16'hA1A1, 0, 0, 0, 0);
      run_batch("ack_beats_err", 1, 1, 0, 16'h0100, 16'h4010, 16'h0, 0, 2, 2, 2);
      run_batch("dual_second_err", 1, 1, 0, 16'h0200, 16'h4012, 16'h0, 1, 0, 0, 1);
      ovr_en = 0;
   endtask

   task automatic test_timeout();
`ifdef WB_J1_TIMEOUT_EN
      run_batch("timeout_abort", 0, 1, 0, 16'h0, 16'h4100, 16'h0, 0, 3, 0, 0);
`else
      int low;
      cfg_wait[sidx % 4] = 0;
      cfg_mode[sidx % 4] = 3;
      @(negedge clk);
      dbus_re = 1; dbus_adr = 16'h4100;
      @(negedge clk);
      low = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!(wb_stb_o && wb_cyc_o && j1_stall)) low++;
      end
      checks++;
      if (low !== 0) begin
         fails++;
         $display("FAIL no_timeout_hold: stb/stall dropped in %0d of 1000 cycles, expected 0", low);
      end
      reset = 1; dbus_re = 0;
      @(negedge clk);
      reset = 0;
      exp_ibus = '0;
      exp_dbus = '0;
`endif
   endtask

   task automatic test_reset_mid_access();
      cfg_wait[sidx % 4] = 5;
      cfg_mode[sidx % 4] = 0;
      @(negedge clk);
      dbus_re = 1; dbus_adr = 16'h4200;
      @(negedge clk);
      @(negedge clk);
      reset = 1; dbus_re = 0;
      @(negedge clk);
      #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || j1_stall !== 1'b0 ||
          dbus_dat_s !== 16'h0 || ibus_dat !== 16'h0 || bus_error !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_access: cyc=%b stb=%b stall=%b ddat=%h idat=%h err=%b expected all 0",
                  wb_cyc_o, wb_stb_o, j1_stall, dbus_dat_s, ibus_dat, bus_error);
      end
      reset = 0;
      exp_ibus = '0;
      exp_dbus = '0;
      run_batch("after_reset_read", 0, 1, 0, 16'h0, 16'h4202, 16'h0, 1, 0, 0, 0);
   endtask

   task automatic test_random();
      logic ire, dre, dwe;
      for (int t = 0; t < 24; t++) begin
         do begin
            ire = 1'($urandom_range(0, 1));
            dre = 1'($urandom_range(0, 1));
            dwe = 1'($urandom_range(0, 1));
         end while (!(ire | dre | dwe));
         run_batch("random", ire, dre, dwe, 16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         cfg_wait[i] = 0;
         cfg_mode[i] = 0;
      end
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
